// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: word type, defaults, FSM encoding and
// stall-vector bit positions used by the pipeline controller.
package instruction_fetch_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    localparam word_t NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    // Bit positions inside the controller's stall vector.
    localparam int unsigned STALL_FETCH_IDX     = 0;
    localparam int unsigned STALL_DECODE_IDX    = 1;
    localparam int unsigned STALL_EXECUTE_IDX   = 2;
    localparam int unsigned STALL_MEMORY_IDX    = 3;
    localparam int unsigned STALL_WRITEBACK_IDX = 4;
    localparam int unsigned STALL_WIDTH         = 5;

    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

    function automatic word_t seq_pc(word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter with the pending-redirect latch that remembers a branch
// resolved while fetch was stalled, and the next-PC priority mux.
module pc_register
    import instruction_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  run,
    input  logic  stall,
    input  logic  flush,
    input  word_t flush_pc,
    input  logic  branch_flag,
    input  word_t branch_target,
    output word_t pc
);

    word_t pc_q, pc_d;
    word_t pending_target_q, pending_target_d;
    logic  pending_valid_q, pending_valid_d;

    always_comb begin
        pc_d             = pc_q;
        pending_target_d = pending_target_q;
        pending_valid_d  = pending_valid_q;
        if (run) begin
            if (flush) begin
                pc_d            = flush_pc;
                pending_valid_d = 1'b0;
            end else if (stall) begin
                if (branch_flag) begin
                    pending_target_d = branch_target;
                    pending_valid_d  = 1'b1;
                end
            end else begin
                // A fresh branch outranks an older pending one; either way pending is consumed.
                if (branch_flag) begin
                    pc_d = branch_target;
                end else if (pending_valid_q) begin
                    pc_d = pending_target_q;
                end else begin
                    pc_d = seq_pc(pc_q);
                end
                pending_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q             <= RESET_PC;
            pending_target_q <= '0;
            pending_valid_q  <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            pending_target_q <= pending_target_d;
            pending_valid_q  <= pending_valid_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: boot/run FSM, instruction ROM interface and the IF/ID
// pipeline register; the PC itself lives in pc_register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT,
    parameter word_t NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_fetch,
    input  logic        stall_decode,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_enable,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid
);

    fetch_state_t state_q, state_d;
    word_t        id_pc_q, id_pc_d;
    word_t        id_instruction_q, id_instruction_d;
    logic         id_valid_q, id_valid_d;
    word_t        pc;

    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clock        (clock),
        .reset        (reset),
        .run          (state_q == FETCH_RUN),
        .stall        (stall_fetch),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .pc           (pc)
    );

    always_comb begin
        state_d          = state_q;
        id_pc_d          = id_pc_q;
        id_instruction_d = id_instruction_q;
        id_valid_d       = id_valid_q;
        case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_RUN;
            end
            default: begin
                if (flush || (stall_fetch && !stall_decode)) begin
                    id_pc_d          = '0;
                    id_instruction_d = NOP_WORD;
                    id_valid_d       = 1'b0;
                end else if (!stall_fetch) begin
                    // The delay-slot word is always committed; redirects only steer the PC.
                    id_pc_d          = pc;
                    id_instruction_d = rom_data;
                    id_valid_d       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= FETCH_BOOT;
            id_pc_q          <= '0;
            id_instruction_q <= NOP_WORD;
            id_valid_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            id_pc_q          <= id_pc_d;
            id_instruction_q <= id_instruction_d;
            id_valid_q       <= id_valid_d;
        end
    end

    assign rom_enable     = (state_q == FETCH_RUN);
    assign rom_address    = pc;
    assign id_pc          = id_pc_q;
    assign id_instruction = id_instruction_q;
    assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a fetch-stream model predicts IF/ID
// and PC after every edge; a negedge monitor compares against the DUT.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall_fetch = 1'b0;
    logic        stall_decode = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        rom_enable;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;

    int checks = 0;
    int failures = 0;

    instruction_fetch dut (
        .clock         (clock),
        .reset         (reset),
        .stall_fetch   (stall_fetch),
        .stall_decode  (stall_decode),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_enable    (rom_enable),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .id_pc         (id_pc),
        .id_instruction(id_instruction),
        .id_valid      (id_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(logic [31:0] a);
        if (a == 32'h0) return 32'h3401_0005;
        if (a == 32'h4) return 32'h3401_0004;
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign rom_data = rom_word(rom_address);

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: architectural fetch stream.
    typedef struct packed {
        logic [31:0] pc;
        logic        en;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
    } expect_t;

    expect_t     sb[$];
    logic        m_boot = 1'b1;
    logic [31:0] m_pc = 32'h0;
    logic        m_pend = 1'b0;
    logic [31:0] m_target = 32'h0;
    expect_t     m_out;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_boot = 1'b1;
            m_pc   = 32'h0;
            m_pend = 1'b0;
            m_out  = '{pc: 32'h0, en: 1'b0, ipc: 32'h0, instr: 32'h0, valid: 1'b0};
            sb.delete();
        end else begin
            if (m_boot) begin
                m_boot = 1'b0;
                m_out.en = 1'b1;
            end else if (flush) begin
                m_pc = flush_pc;
                m_pend = 1'b0;
                {m_out.ipc, m_out.instr, m_out.valid} = '0;
            end else if (stall_fetch) begin
                if (!stall_decode) {m_out.ipc, m_out.instr, m_out.valid} = '0;
                if (branch_flag) begin
                    m_pend = 1'b1;
                    m_target = branch_target;
                end
            end else begin
                m_out.ipc = m_pc;
                m_out.instr = rom_word(m_pc);
                m_out.valid = 1'b1;
                if (branch_flag) m_pc = branch_target;
                else if (m_pend) m_pc = m_target;
                else m_pc = m_pc + 32'd4;
                m_pend = 1'b0;
            end
            m_out.pc = m_pc;
            sb.push_back(m_out);
        end
    end

    always @(negedge clock) begin
        if (reset && sb.size() > 0) begin
            expect_t e;
            e = sb.pop_front();
            check("sb_rom_address", rom_address, e.pc);
            check("sb_rom_enable", {31'b0, rom_enable}, {31'b0, e.en});
            check("sb_id_pc", id_pc, e.ipc);
            check("sb_id_instruction", id_instruction, e.instr);
            check("sb_id_valid", {31'b0, id_valid}, {31'b0, e.valid});
        end
    end

    task automatic cycle(logic sf, logic sd, logic fl, logic [31:0] fpc, logic bf,
                         logic [31:0] bt);
        stall_fetch   = sf;
        stall_decode  = sd;
        flush         = fl;
        flush_pc      = fpc;
        branch_flag   = bf;
        branch_target = bt;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_rom_enable"}, {31'b0, rom_enable}, 32'h0);
        check({tag, "_rom_address"}, rom_address, 32'h0);
        check({tag, "_id_pc"}, id_pc, 32'h0);
        check({tag, "_id_instruction"}, id_instruction, 32'h0);
        check({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Boot then first two fetches.
        idle();
        check("boot_rom_enable", {31'b0, rom_enable}, 32'h1);
        check("boot_id_valid", {31'b0, id_valid}, 32'h0);
        idle();
        check("first_id_pc", id_pc, 32'h0);
        check("first_id_instruction", id_instruction, 32'h3401_0005);
        check("first_id_valid", {31'b0, id_valid}, 32'h1);
        idle();
        check("second_id_pc", id_pc, 32'h4);

        // Branch at 0x10 to 0x40 with delay slot.
        repeat (3) idle();
        check("branch_id_pc", id_pc, 32'h10);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        check("delay_slot_id_pc", id_pc, 32'h14);
        check("delay_slot_valid", {31'b0, id_valid}, 32'h1);
        idle();
        check("target_id_pc", id_pc, 32'h40);
        idle();
        check("target_next_id_pc", id_pc, 32'h44);

        // Full stall with branch latched into pending.
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
        check("stall1_id_pc", id_pc, 32'h44);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall3_id_pc", id_pc, 32'h44);
        idle();
        check("stall_release_id_pc", id_pc, 32'h48);
        idle();
        check("pending_target_id_pc", id_pc, 32'h80);

        // Fetch-only stall inserts one bubble.
        cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("bubble_id_valid", {31'b0, id_valid}, 32'h0);
        check("bubble_id_instruction", id_instruction, 32'h0);
        idle();
        check("after_bubble_id_pc", id_pc, 32'h20);
        check("after_bubble_valid", {31'b0, id_valid}, 32'h1);

        // Flush overrides branch and stalls.
        cycle(1'b1, 1'b1, 1'b1, 32'h120, 1'b1, 32'h200);
        check("flush_id_valid", {31'b0, id_valid}, 32'h0);
        idle();
        check("flush_target_id_pc", id_pc, 32'h120);
        idle();
        check("flush_no_pending_id_pc", id_pc, 32'h124);

        // PC wrap.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        idle();
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_rom_address", rom_address, 32'h0);
        idle();
        check("wrap_next_instruction", id_instruction, 32'h3401_0005);

        // Reset mid-stall with a pending redirect.
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        stall_fetch = 1'b0;
        stall_decode = 1'b0;
        branch_flag = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        idle();
        idle();
        check("after_reset_id_pc", id_pc, 32'h0);
        check("after_reset_valid", {31'b0, id_valid}, 32'h1);
        idle();
        check("after_reset_no_pending", id_pc, 32'h4);

        // Randomized traffic, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            logic        sf, sd, fl, bf;
            logic [31:0] fpc, bt;
            sf  = ($urandom_range(0, 3) == 0);
            sd  = sf && ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 19) == 0);
            bf  = ($urandom_range(0, 4) == 0);
            fpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            bt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8
                                             : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            cycle(sf, sd, fl, fpc, bf, bt);
        end
        idle();
        idle();
        @(negedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
